gmii_to_axi: RTL and testbench

Single-clock GMII receive-side packer: takes the 8-bit GMII receive byte stream, optionally strips preamble/SFD, and packs frame bytes into 64-bit AXI-Stream words with contiguous `tkeep`, `tlast` and an error flag on `tuser`. It is the receive-direction counterpart of the 64-bit-to-GMII transmit path and sits between the RGMII/GMII receive interface and the 64-bit datapath. A small output FIFO absorbs `axis_tready` back-pressure. Overflow truncates the frame and marks it with an error terminator.

---
 rtl/gmii_to_axi.sv | 206 ++++++++++++++++++++
 tb/tb_gmii_to_axi.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_to_axi.sv
// GMII receive packer: strips preamble/SFD (optional), packs frame bytes into
// 64-bit AXI-Stream words and buffers them in a small show-ahead FIFO.
module gmii_to_axi #(
  parameter int FIFO_DEPTH     = 4,
  parameter bit STRIP_PREAMBLE = 1'b1
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  input  logic        axis_tready,
  output logic        axis_tvalid,
  output logic [63:0] axis_tdata,
  output logic [7:0]  axis_tkeep,
  output logic        axis_tlast,
  output logic        axis_tuser,
  output logic        rx_overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } word_t;

  state_t      state_q, state_d;
  logic        dv_d_q;
  logic [2:0]  lane_cnt_q, lane_cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic        err_q, err_d;
  logic        term_pending_q, term_pending_d;
  logic        overflow_q, overflow_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  word_t fifo_mem [FIFO_DEPTH];
  word_t push_word, head;
  logic  push_req, push_en;
  logic  fifo_full, fifo_pop, can_push, frame_start;
  logic [63:0] acc_next;

  assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
  assign fifo_pop    = (count_q != '0) && axis_tready;
  assign can_push    = !fifo_full || fifo_pop;
  assign frame_start = gmii_rx_dv && !dv_d_q;
  // Lane 0 starts a fresh word, so bytes above the write lane are always zero.
  assign acc_next    = (lane_cnt_q == 3'd0) ? {56'b0, gmii_rxd}
                                            : (acc_q | ({56'b0, gmii_rxd} << {lane_cnt_q, 3'b000}));

  // Receive FSM: next state, packing datapath and FIFO push request.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d        = state_q;
    lane_cnt_d     = lane_cnt_q;
    acc_d          = acc_q;
    hold_d         = hold_q;
    hold_valid_d   = hold_valid_q;
    err_d          = err_q;
    term_pending_d = term_pending_q;
    overflow_d     = 1'b0;
    push_req       = 1'b0;
    push_word      = '0;

    unique case (state_q)
      IDLE: begin
        err_d        = 1'b0;
        lane_cnt_d   = 3'd0;
        hold_valid_d = 1'b0;
        if (frame_start) begin
          err_d = gmii_rx_er;
          if (STRIP_PREAMBLE) begin
            state_d = PREAMBLE;
          end else begin
            state_d    = DATA;
            acc_d      = {56'b0, gmii_rxd};
            lane_cnt_d = 3'd1;
          end
        end
      end
      PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = IDLE;
        end else begin
          err_d = err_q | gmii_rx_er;
          if (gmii_rxd == 8'hD5) begin
            state_d    = DATA;
            lane_cnt_d = 3'd0;
          end
        end
      end
      DATA: begin
        if (gmii_rx_dv) begin
          err_d = err_q | gmii_rx_er;
          acc_d = acc_next;
          if (hold_valid_q) begin
            push_req     = 1'b1;
            push_word    = '{data: hold_q, keep: 8'hFF, last: 1'b0, user: 1'b0};
            hold_valid_d = 1'b0;
          end
          if (lane_cnt_q == 3'd7) begin
            hold_d       = acc_next;
            hold_valid_d = 1'b1;
            lane_cnt_d   = 3'd0;
          end else begin
            lane_cnt_d = lane_cnt_q + 3'd1;
          end
        end else begin
          state_d      = IDLE;
          hold_valid_d = 1'b0;
          lane_cnt_d   = 3'd0;
          if (hold_valid_q) begin
            push_req  = 1'b1;
            push_word = '{data: hold_q, keep: 8'hFF, last: 1'b1, user: err_q};
          end else if (lane_cnt_q != 3'd0) begin
            push_req  = 1'b1;
            push_word = '{data: acc_q, keep: 8'hFF >> (4'd8 - {1'b0, lane_cnt_q}),
                          last: 1'b1, user: err_q};
          end
        end
      end
      DROP: begin
        term_pending_d = 1'b1;
        if (!gmii_rx_dv && can_push) begin
          push_req       = 1'b1;
          push_word      = '{data: 64'd0, keep: 8'h01, last: 1'b1, user: 1'b1};
          term_pending_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A push that finds the FIFO full is discarded and the frame is truncated.
    push_en = push_req && can_push;
    if (push_req && !can_push) begin
      overflow_d     = 1'b1;
      state_d        = DROP;
      term_pending_d = 1'b1;
      hold_valid_d   = 1'b0;
      lane_cnt_d     = 3'd0;
    end
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_en);
    rd_ptr_d = rd_ptr_q + AW'(fifo_pop);
    count_d  = count_q + CW'(push_en) - CW'(fifo_pop);
  end

  // State and control registers.
  always_ff @(posedge gmii_rx_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q        <= IDLE;
      dv_d_q         <= 1'b1;
      lane_cnt_q     <= 3'd0;
      acc_q          <= '0;
      hold_q         <= '0;
      hold_valid_q   <= 1'b0;
      err_q          <= 1'b0;
      term_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      dv_d_q         <= gmii_rx_dv;
      lane_cnt_q     <= lane_cnt_d;
      acc_q          <= acc_d;
      hold_q         <= hold_d;
      hold_valid_q   <= hold_valid_d;
      err_q          <= err_d;
      term_pending_q <= term_pending_d;
      overflow_q     <= overflow_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge gmii_rx_clk) begin
    // NOTE: storage is not reset; outputs are gated by tvalid so stale entries never show.
    if (push_en) fifo_mem[wr_ptr_q] <= push_word;
  end

  assign head        = fifo_mem[rd_ptr_q];
  assign axis_tvalid = (count_q != '0);
  assign axis_tdata  = axis_tvalid ? head.data : 64'd0;
  assign axis_tkeep  = axis_tvalid ? head.keep : 8'd0;
  assign axis_tlast  = axis_tvalid && head.last;
  assign axis_tuser  = axis_tvalid && head.user;
  assign rx_overflow = overflow_q;

endmodule

// File: tb/tb_gmii_to_axi.sv
// Scoreboard bench for gmii_to_axi: a frame-level model fills expected-word
// queues at stimulus time; independent monitors pop and compare DUT output.
module tb_gmii_to_axi;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;
  typedef logic [7:0] bq_t[$];
  typedef beat_t beat_q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, dv, er, tready;
  logic [7:0]  rxd;
  logic        tvalid, tlast, tuser, ovf;
  logic [63:0] tdata;
  logic [7:0]  tkeep;

  logic        dv2, er2, tready2;
  logic [7:0]  rxd2;
  logic        tvalid2, tlast2, tuser2, ovf2;
  logic [63:0] tdata2;
  logic [7:0]  tkeep2;

  gmii_to_axi #(.FIFO_DEPTH(4), .STRIP_PREAMBLE(1'b1)) dut (
    .gmii_rx_clk(clk), .rst(rst), .gmii_rx_dv(dv), .gmii_rx_er(er), .gmii_rxd(rxd),
    .axis_tready(tready), .axis_tvalid(tvalid), .axis_tdata(tdata), .axis_tkeep(tkeep),
    .axis_tlast(tlast), .axis_tuser(tuser), .rx_overflow(ovf));

  gmii_to_axi #(.FIFO_DEPTH(4), .STRIP_PREAMBLE(1'b0)) dut_np (
    .gmii_rx_clk(clk), .rst(rst), .gmii_rx_dv(dv2), .gmii_rx_er(er2), .gmii_rxd(rxd2),
    .axis_tready(tready2), .axis_tvalid(tvalid2), .axis_tdata(tdata2), .axis_tkeep(tkeep2),
    .axis_tlast(tlast2), .axis_tuser(tuser2), .rx_overflow(ovf2));

  beat_t exp_q[$];
  beat_t exp2_q[$];
  int total = 0;
  int bad = 0;
  int ovf_cnt = 0;
  bit rand_ready = 1'b0;
  logic force_ready = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Frame-level reference: payload split into 8-byte words, little-endian lanes.
  task automatic model_words(input bq_t pl, input logic err, output beat_q_t ws);
    int n;
    ws = {};
    n = pl.size();
    for (int w = 0; w * 8 < n; w++) begin
      beat_t b;
      int cnt;
      b = '0;
      cnt = 0;
      for (int j = 0; j < 8; j++) begin
        if (w * 8 + j < n) begin
          b.data[8*j +: 8] = pl[w*8+j];
          cnt++;
        end
      end
      b.keep = 8'((1 << cnt) - 1);
      b.last = (w * 8 + 8 >= n);
      b.user = b.last & err;
      ws.push_back(b);
    end
  endtask

  task automatic expect_frame(input bq_t pl, input logic err);
    beat_q_t ws;
    model_words(pl, err, ws);
    foreach (ws[i]) exp_q.push_back(ws[i]);
  endtask

  task automatic drive_byte(input logic v, input logic e, input logic [7:0] d);
    dv = v; er = e; rxd = d;
    @(posedge clk); #1;
  endtask

  task automatic drive_frame(input int plen, input bq_t pl, input int er_idx, input int ifg);
    for (int i = 0; i < plen; i++) drive_byte(1'b1, 1'b0, 8'h55);
    drive_byte(1'b1, 1'b0, 8'hD5);
    foreach (pl[i]) drive_byte(1'b1, (i == er_idx), pl[i]);
    for (int i = 0; i < ifg; i++) drive_byte(1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && i < 2000) begin
      @(posedge clk); #1;
      i++;
    end
    check(name, 128'(exp_q.size() + exp2_q.size()), 128'd0);
  endtask

  // Downstream ready: forced value, or random with at most 3 stalled cycles in a row.
  initial begin
    int stall;
    stall = 0;
    tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rand_ready) begin
        if (stall >= 3) tready = 1'b1;
        else tready = 1'($urandom_range(0, 1));
        stall = tready ? 0 : stall + 1;
      end else begin
        tready = force_ready;
        stall = 0;
      end
    end
  end

  // Monitor for the preamble-stripping instance.
  initial begin
    beat_t got, held, e;
    bit was_stalled;
    was_stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (ovf) ovf_cnt++;
      got = '{data: tdata, keep: tkeep, last: tlast, user: tuser};
      if (was_stalled) check("stall_stable", {tvalid, got}, {1'b1, held});
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          check("word", 128'(got), 128'(e));
        end
      end
      was_stalled = tvalid && !tready && !rst;
      held = got;
    end
  end

  // Monitor for the pass-through instance.
  initial begin
    beat_t got, e;
    forever begin
      @(negedge clk);
      got = '{data: tdata2, keep: tkeep2, last: tlast2, user: tuser2};
      if (tvalid2 && tready2) begin
        if (exp2_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word_np: got %h expected none", got);
        end else begin
          e = exp2_q.pop_front();
          check("word_np", 128'(got), 128'(e));
        end
      end
    end
  end

  initial begin
    bq_t pl;
    beat_q_t ws;
    int o;
    rst = 1'b1; dv = 1'b0; er = 1'b0; rxd = 8'h00;
    dv2 = 1'b0; er2 = 1'b0; rxd2 = 8'h00; tready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 128'(tvalid), 128'd0);
    check("rst_tdata",  128'(tdata),  128'd0);
    check("rst_tkeep",  128'(tkeep),  128'd0);
    check("rst_tlast",  128'(tlast),  128'd0);
    check("rst_tuser",  128'(tuser),  128'd0);
    check("rst_ovf",    128'(ovf),    128'd0);
    rst = 1'b0;
    repeat (2) drive_byte(1'b0, 1'b0, 8'h00);

    // 64-byte frame, full last word.
    pl = {};
    for (int i = 0; i < 64; i++) pl.push_back(8'(i));
    expect_frame(pl, 1'b0);
    drive_frame(7, pl, -1, 12);

    // 61-byte frame, partial last word.
    pl = {};
    for (int i = 0; i < 61; i++) pl.push_back(8'(i));
    expect_frame(pl, 1'b0);
    drive_frame(7, pl, -1, 12);

    // 64-byte frame with one errored byte.
    pl = {};
    for (int i = 0; i < 64; i++) pl.push_back(8'(i));
    expect_frame(pl, 1'b1);
    drive_frame(7, pl, 20, 12);

    // Preamble-only burst: no output, no overflow.
    o = ovf_cnt;
    repeat (5) drive_byte(1'b1, 1'b0, 8'h55);
    repeat (12) drive_byte(1'b0, 1'b0, 8'h00);
    wait_drain("drain_basic");
    check("preamble_only_ovf", 128'(ovf_cnt - o), 128'd0);

    // Overflow with the sink stalled.
    force_ready = 1'b0;
    repeat (2) drive_byte(1'b0, 1'b0, 8'h00);
    o = ovf_cnt;
    pl = {};
    for (int i = 0; i < 64; i++) pl.push_back(8'(i));
    model_words(pl, 1'b0, ws);
    for (int i = 0; i < 4; i++) exp_q.push_back(ws[i]);
    exp_q.push_back('{data: 64'd0, keep: 8'h01, last: 1'b1, user: 1'b1});
    drive_frame(7, pl, -1, 4);
    check("ovf_pulses", 128'(ovf_cnt - o), 128'd1);
    check("ovf_stalled_q", 128'(exp_q.size()), 128'd5);
    force_ready = 1'b1;
    wait_drain("drain_ovf");

    // Reset mid-frame while dv stays high; the rest of the frame is ignored.
    pl = {};
    for (int i = 0; i < 30; i++) pl.push_back(8'(8'h80 + i));
    pl[12] = 8'hD5;
    model_words(pl, 1'b0, ws);
    exp_q.push_back(ws[0]);
    repeat (7) drive_byte(1'b1, 1'b0, 8'h55);
    drive_byte(1'b1, 1'b0, 8'hD5);
    foreach (pl[i]) begin
      rst = (i == 10);
      drive_byte(1'b1, 1'b0, pl[i]);
    end
    rst = 1'b0;
    repeat (12) drive_byte(1'b0, 1'b0, 8'h00);
    pl = {};
    for (int i = 0; i < 16; i++) pl.push_back(8'(i));
    expect_frame(pl, 1'b0);
    drive_frame(7, pl, -1, 12);
    wait_drain("drain_rst");

    // Pass-through instance: AA BB CC with no preamble.
    exp2_q.push_back('{data: 64'h0000000000CCBBAA, keep: 8'h07, last: 1'b1, user: 1'b0});
    dv2 = 1'b1; rxd2 = 8'hAA; @(posedge clk); #1;
    rxd2 = 8'hBB; @(posedge clk); #1;
    rxd2 = 8'hCC; @(posedge clk); #1;
    dv2 = 1'b0; rxd2 = 8'h00;
    repeat (4) @(posedge clk);
    #1;

    // Random frames with random bounded back-pressure.
    rand_ready = 1'b1;
    o = ovf_cnt;
    for (int f = 0; f < 25; f++) begin
      int len, plen, eidx;
      len = $urandom_range(0, 70);
      plen = $urandom_range(1, 8);
      eidx = -1;
      if (len > 0 && $urandom_range(0, 3) == 0) eidx = $urandom_range(0, len - 1);
      pl = {};
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
      expect_frame(pl, eidx >= 0);
      drive_frame(plen, pl, eidx, $urandom_range(12, 20));
    end
    rand_ready = 1'b0;
    wait_drain("drain_random");
    check("random_ovf", 128'(ovf_cnt - o), 128'd0);
    repeat (10) @(posedge clk);
    #1;
    check("final_empty", 128'(tvalid || tvalid2), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
